// File: rtl/vector_load_12_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_load_12_pkg
//  Description : Shared constants and element type for the 12-element vector
//                loader and its shadow buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
package vector_load_12_pkg;

    localparam int c_VEC_LEN  = 12;
    localparam int c_IDX_W    = 4;
    localparam int c_IN_WIDTH = 10;

    typedef logic signed [c_IN_WIDTH-1:0] elem_t;

endpackage
`default_nettype wire

// File: rtl/vector_shadow_reg.sv
`default_nettype none
// ============================================================================
//  Module      : vector_shadow_reg
//  Description : Indexed write buffer with parallel read. It collects the
//                leading elements of a vector while the output register
//                still holds the previous vector.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_shadow_reg
    import vector_load_12_pkg::*;
#(
    parameter int IN_WIDTH = c_IN_WIDTH,
    parameter int DEPTH    = c_VEC_LEN - 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_we,
    input  logic [c_IDX_W-1:0]         i_idx,
    input  logic signed [IN_WIDTH-1:0] i_data,
    output logic signed [IN_WIDTH-1:0] o_vec [DEPTH]
);

    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        logic signed [IN_WIDTH-1:0] r_data;

        // Capture the element when the write index selects this slot
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_data <= '0;
            end else if (i_we && (i_idx == c_IDX_W'(i))) begin
                r_data <= i_data;
            end
        end

        assign o_vec[i] = r_data;
    end

endmodule
`default_nettype wire

// File: rtl/vector_load_12.sv
`default_nettype none
// ============================================================================
//  Module      : vector_load_12
//  Description : Serial-to-parallel feeder for the 12-element vector adder.
//                Element pairs are gathered in shadow buffers. The final
//                element is merged straight into the output register, so a
//                back-to-back stream needs no stall.
//  Revision    : 1.0 - initial release
// ============================================================================
module vector_load_12
    import vector_load_12_pkg::*;
#(
    parameter int IN_WIDTH = c_IN_WIDTH,
    parameter int VEC_LEN  = c_VEC_LEN
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enable,
    input  logic                       inValid,
    input  logic                       inLast,
    input  logic signed [IN_WIDTH-1:0] inA,
    input  logic signed [IN_WIDTH-1:0] inB,
    output logic signed [IN_WIDTH-1:0] A0,
    output logic signed [IN_WIDTH-1:0] A1,
    output logic signed [IN_WIDTH-1:0] A2,
    output logic signed [IN_WIDTH-1:0] A3,
    output logic signed [IN_WIDTH-1:0] A4,
    output logic signed [IN_WIDTH-1:0] A5,
    output logic signed [IN_WIDTH-1:0] A6,
    output logic signed [IN_WIDTH-1:0] A7,
    output logic signed [IN_WIDTH-1:0] A8,
    output logic signed [IN_WIDTH-1:0] A9,
    output logic signed [IN_WIDTH-1:0] A10,
    output logic signed [IN_WIDTH-1:0] A11,
    output logic signed [IN_WIDTH-1:0] B0,
    output logic signed [IN_WIDTH-1:0] B1,
    output logic signed [IN_WIDTH-1:0] B2,
    output logic signed [IN_WIDTH-1:0] B3,
    output logic signed [IN_WIDTH-1:0] B4,
    output logic signed [IN_WIDTH-1:0] B5,
    output logic signed [IN_WIDTH-1:0] B6,
    output logic signed [IN_WIDTH-1:0] B7,
    output logic signed [IN_WIDTH-1:0] B8,
    output logic signed [IN_WIDTH-1:0] B9,
    output logic signed [IN_WIDTH-1:0] B10,
    output logic signed [IN_WIDTH-1:0] B11,
    output logic                       outReady,
    output logic                       earlyOutReady,
    output logic                       frameErr
);

    // The port list is hard-wired to twelve elements, so any other length
    // cannot work.
    if (VEC_LEN != 12) begin : g_bad_vec_len
        $error("vector_load_12: VEC_LEN must be 12");
    end

    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(VEC_LEN - 1);

    logic [c_IDX_W-1:0]         r_idx;
    logic signed [IN_WIDTH-1:0] r_a [VEC_LEN];
    logic signed [IN_WIDTH-1:0] r_b [VEC_LEN];
    logic                       r_out_ready;
    logic                       r_frame_err;

    logic                       w_acc;
    logic                       w_last_slot;
    logic                       w_shadow_we;
    logic signed [IN_WIDTH-1:0] w_shadow_a [VEC_LEN-1];
    logic signed [IN_WIDTH-1:0] w_shadow_b [VEC_LEN-1];

    assign w_acc       = enable & inValid;
    assign w_last_slot = (r_idx == c_LAST_IDX);
    // Only a well-framed element in a fill slot is kept; a premature last is dropped.
    assign w_shadow_we = w_acc & ~w_last_slot & ~inLast;

    vector_shadow_reg #(
        .IN_WIDTH (IN_WIDTH),
        .DEPTH    (VEC_LEN - 1)
    ) u_shadow_a (
        .clk    (clk),
        .rst    (reset),
        .i_we   (w_shadow_we),
        .i_idx  (r_idx),
        .i_data (inA),
        .o_vec  (w_shadow_a)
    );

    vector_shadow_reg #(
        .IN_WIDTH (IN_WIDTH),
        .DEPTH    (VEC_LEN - 1)
    ) u_shadow_b (
        .clk    (clk),
        .rst    (reset),
        .i_we   (w_shadow_we),
        .i_idx  (r_idx),
        .i_data (inB),
        .o_vec  (w_shadow_b)
    );

    // Element counter, framing checks, and the output register update on completion
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_idx       <= '0;
            r_out_ready <= 1'b0;
            r_frame_err <= 1'b0;
            for (int i = 0; i < VEC_LEN; i++) begin
                r_a[i] <= '0;
                r_b[i] <= '0;
            end
        end else begin
            r_out_ready <= 1'b0;
            r_frame_err <= 1'b0;
            if (w_acc) begin
                if (!w_last_slot) begin
                    if (inLast) begin
                        r_idx       <= '0;
                        r_frame_err <= 1'b1;
                    end else begin
                        r_idx <= r_idx + c_IDX_W'(1);
                    end
                end else begin
                    r_idx <= '0;
                    if (inLast) begin
                        r_out_ready <= 1'b1;
                        for (int i = 0; i < VEC_LEN - 1; i++) begin
                            r_a[i] <= w_shadow_a[i];
                            r_b[i] <= w_shadow_b[i];
                        end
                        r_a[VEC_LEN-1] <= inA;
                        r_b[VEC_LEN-1] <= inB;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                end
            end
        end
    end

    assign outReady      = r_out_ready;
    assign frameErr      = r_frame_err;
    assign earlyOutReady = w_last_slot & enable;

    assign A0  = r_a[0];
    assign A1  = r_a[1];
    assign A2  = r_a[2];
    assign A3  = r_a[3];
    assign A4  = r_a[4];
    assign A5  = r_a[5];
    assign A6  = r_a[6];
    assign A7  = r_a[7];
    assign A8  = r_a[8];
    assign A9  = r_a[9];
    assign A10 = r_a[10];
    assign A11 = r_a[11];
    assign B0  = r_b[0];
    assign B1  = r_b[1];
    assign B2  = r_b[2];
    assign B3  = r_b[3];
    assign B4  = r_b[4];
    assign B5  = r_b[5];
    assign B6  = r_b[6];
    assign B7  = r_b[7];
    assign B8  = r_b[8];
    assign B9  = r_b[9];
    assign B10 = r_b[10];
    assign B11 = r_b[11];

endmodule
`default_nettype wire
